// File: rtl/cond_pkg.sv
// cond_pkg
// Shared definitions for the condition unit: the condition-code encodings
// EQ..NV, the bit positions of Z/N/C/V in a flag nibble, and the state
// encoding of the predication-window FSM.
package cond_pkg;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam int Z_BIT = 0;
  localparam int N_BIT = 1;
  localparam int C_BIT = 2;
  localparam int V_BIT = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } cond_state_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval
// Purely combinational condition evaluator.
// Ports:
//   flags_i  flag nibble, [0]=Z [1]=N [2]=C [3]=V
//   code_i   condition code (EQ..NV)
//   cond_o   1 when the condition holds for flags_i
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] code_i,
  output logic       cond_o
);

  logic z, n, c, v;

  always_comb begin
    z = flags_i[Z_BIT];
    n = flags_i[N_BIT];
    c = flags_i[C_BIT];
    v = flags_i[V_BIT];
    cond_o = 1'b0;
    case (code_i)
      CC_EQ: cond_o = z;
      CC_NE: cond_o = ~z;
      CC_CS: cond_o = c;
      CC_CC: cond_o = ~c;
      CC_MI: cond_o = n;
      CC_PL: cond_o = ~n;
      CC_VS: cond_o = v;
      CC_VC: cond_o = ~v;
      CC_HI: cond_o = c & ~z;
      CC_LS: cond_o = ~c | z;
      CC_GE: cond_o = (n == v);
      CC_LT: cond_o = (n != v);
      CC_GT: cond_o = ~z & (n == v);
      CC_LE: cond_o = z | (n != v);
      CC_AL: cond_o = 1'b1;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit
// Banked Z/N/C/V flag registers, a one-cycle registered condition evaluator
// and a predication-window FSM that applies one latched condition, with
// per-slot then/else polarity, to the next it_len accepted requests.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flags_we/wbank/wdata       flag bank write (independent of stall and FSM)
//   stall                      freeze result registers and FSM
//   req_valid/code/bank        evaluation request
//   it_start/it_len/it_mask    open a predication window with the request
//   cond_valid, cond_out       registered result
//   it_active                  predication window open
//   it_err                     sticky illegal-start flag
//   flags_rd                   combinational read of bank req_bank
// Build option: define COND_FWD_EN to forward a same-cycle flag write to the
// evaluator and flags_rd; otherwise the write is visible from the next cycle.
//
// state     | meaning
// ST_IDLE   | requests evaluate req_code on req_bank, unpredicated
// ST_ACTIVE | requests evaluate latched code/bank XOR it_mask[slot]
module cond_unit
  import cond_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int MAX_IT_LEN = 4,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int LEN_W      = $clog2(MAX_IT_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flags_we,
  input  logic [BANK_W-1:0]     flags_wbank,
  input  logic [3:0]            flags_wdata,
  input  logic                  stall,
  input  logic                  req_valid,
  input  logic [3:0]            req_code,
  input  logic [BANK_W-1:0]     req_bank,
  input  logic                  it_start,
  input  logic [LEN_W-1:0]      it_len,
  input  logic [MAX_IT_LEN-1:0] it_mask,
  output logic                  cond_valid,
  output logic                  cond_out,
  output logic                  it_active,
  output logic                  it_err,
  output logic [3:0]            flags_rd
);

  localparam int SLOT_W = (MAX_IT_LEN > 1) ? $clog2(MAX_IT_LEN) : 1;

  logic [3:0]            bank_q [NUM_BANKS];
  cond_state_e           state_q;
  logic [3:0]            it_code_q;
  logic [BANK_W-1:0]     it_bank_q;
  logic [MAX_IT_LEN-1:0] it_mask_q;
  logic [LEN_W-1:0]      remain_q;
  logic [SLOT_W-1:0]     slot_q;
  logic                  cond_valid_q;
  logic                  cond_out_q;
  logic                  it_err_q;

  logic [3:0]            sel_code;
  logic [BANK_W-1:0]     sel_bank;
  logic [3:0]            sel_flags;
  logic [3:0]            rd_flags;
  logic                  eval_raw;
  logic                  cond_d;
  logic                  len_bad;

  // Bank reads go through a loop so a select beyond NUM_BANKS reads zero.
  always_comb begin
    sel_code  = (state_q == ST_ACTIVE) ? it_code_q : req_code;
    sel_bank  = (state_q == ST_ACTIVE) ? it_bank_q : req_bank;
    sel_flags = '0;
    rd_flags  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sel_bank == BANK_W'(b)) sel_flags = bank_q[b];
      if (req_bank == BANK_W'(b)) rd_flags  = bank_q[b];
    end
`ifdef COND_FWD_EN
    if (flags_we && (flags_wbank == sel_bank)) sel_flags = flags_wdata;
    if (flags_we && (flags_wbank == req_bank)) rd_flags  = flags_wdata;
`endif
  end

  cond_eval u_eval (
    .flags_i (sel_flags),
    .code_i  (sel_code),
    .cond_o  (eval_raw)
  );

  always_comb begin
    cond_d  = (state_q == ST_ACTIVE) ? (eval_raw ^ it_mask_q[slot_q]) : eval_raw;
    len_bad = (it_len == '0) || (it_len > LEN_W'(MAX_IT_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
    end else if (flags_we) begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (flags_wbank == BANK_W'(b)) bank_q[b] <= flags_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      it_code_q    <= '0;
      it_bank_q    <= '0;
      it_mask_q    <= '0;
      remain_q     <= '0;
      slot_q       <= '0;
      cond_valid_q <= 1'b0;
      cond_out_q   <= 1'b0;
      it_err_q     <= 1'b0;
    end else if (!stall) begin
      cond_valid_q <= req_valid;
      if (req_valid) begin
        cond_out_q <= cond_d;
        if (state_q == ST_IDLE) begin
          if (it_start) begin
            if (len_bad) begin
              it_err_q <= 1'b1;
            end else begin
              it_code_q <= req_code;
              it_bank_q <= req_bank;
              it_mask_q <= it_mask;
              remain_q  <= it_len;
              slot_q    <= '0;
              state_q   <= ST_ACTIVE;
            end
          end
        end else begin
          // A start inside an open window is rejected but still uses a slot.
          if (it_start) it_err_q <= 1'b1;
          if (remain_q == LEN_W'(1)) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            slot_q   <= '0;
          end else begin
            remain_q <= remain_q - LEN_W'(1);
            slot_q   <= slot_q + SLOT_W'(1);
          end
        end
      end
    end
  end

  assign cond_valid = cond_valid_q;
  assign cond_out   = cond_out_q;
  assign it_active  = (state_q == ST_ACTIVE);
  assign it_err     = it_err_q;
  assign flags_rd   = rd_flags;

endmodule

// File: doc/cond_unit.md
# cond_unit

Parametrised condition unit for the data path: holds NUM_BANKS banked flag registers (Z N C V), evaluates all 16 condition codes against a selected bank with a one-cycle registered result, and runs a predication window FSM that conditions the next up to MAX_IT_LEN instructions on a single latched condition with per-slot then/else polarity. It sits between the ALU flag outputs and the control unit's branch/conditional-execute logic.

## Interface
- NUM_BANKS, 2, number of independent flag registers (≥1)
- MAX_IT_LEN, 4, maximum predication window length (1..8)
- BANK_W, $clog2(NUM_BANKS) (min 1), bank select width (derived)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flags_we  in  1  write flags_wdata into bank flags_wbank
- flags_wbank  in  BANK_W  bank written
- flags_wdata  in  4  flag write data, bit order [0]=Z [1]=N [2]=C [3]=V
- stall  in  1  freeze evaluation pipeline and FSM
- req_valid  in  1  evaluation request this cycle
- req_code  in  4  condition code
- req_bank  in  BANK_W  bank evaluated
- it_start  in  1  open predication window (qualified by req_valid)
- it_len  in  $clog2(MAX_IT_LEN+1)  window length
- it_mask  in  MAX_IT_LEN  per-slot polarity, bit i for slot i: 0=then, 1=else
- cond_valid  out  1  registered result valid
- cond_out  out  1  registered condition result
- it_active  out  1  predication window open
- it_err  out  1  sticky illegal-start flag
- flags_rd  out  4  current contents of bank req_bank (combinational)

## Operation
- Codes: 0 EQ Z; 1 NE !Z; 2 CS/HS C; 3 CC/LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Flag writes occur every cycle flags_we=1, independent of stall and FSM.
- FSM states IDLE, ACTIVE; slot counter and remaining count.
- IDLE: req_valid & !stall → cond_out = eval(req_code, req_bank), cond_valid=1. If it_start also set: latch it_code=req_code, it_bank=req_bank, it_mask, remaining=it_len, slot=0, go ACTIVE; the starting request's own result is unpredicated.
- it_start with it_len=0 or >MAX_IT_LEN: ignored, it_err set.
- ACTIVE: req_valid & !stall → cond_out = eval(it_code, it_bank) XOR it_mask[slot]; req_code/req_bank ignored; slot+1, remaining−1; at remaining=1 → IDLE.
- it_start while ACTIVE: ignored for FSM, it_err set; request still consumes a slot.
- req_valid=0 & !stall: cond_valid=0 next cycle, cond_out holds, FSM holds.
- stall=1: cond_valid, cond_out, FSM, counters all hold.
- it_err clears only on reset.

## Timing
- Result latency 1 cycle: request at edge n → cond_valid/cond_out at n+1.
- it_active rises cycle after accepted it_start; falls cycle after last slot consumed.
- Reset: all banks 4'b0000, cond_valid 0, cond_out 0, it_active 0, it_err 0, state IDLE, counters 0.
- Reset overrides all inputs in same cycle; window closed mid-operation with no result.

## Configuration
- COND_FWD_EN defined: flag write and evaluation on same bank in same cycle uses flags_wdata (forwarded); flags_rd also forwards.
- Undefined: evaluation uses pre-write bank contents; new flags visible from next cycle.

## Structure
- Shared package cond_pkg: condition code localparams (EQ..NV), flag bit indices Z_BIT=0 N_BIT=1 C_BIT=2 V_BIT=3, FSM state encoding.
- Sub-module cond_eval: pure combinational (flags, code) → cond, instantiated once.

## Test plan
- Reset, write bank0=4'b0001 (Z), request EQ bank0 → next cycle cond_valid=1, cond_out=1; NE → 0; NV → 0; AL → 1.
- bank1=4'b0010 (N), bank0=0; PL bank1 → 0, PL bank0 → 1; LT bank1 → 1.
- Same-cycle write bank0=4'b0001 + EQ bank0 from zero: cond_out=1 with COND_FWD_EN, 0 without.
- it_start code EQ, len=3, mask=3'b010, Z=1; three requests with req_code=NV → results 1,0,1; it_active drops after third.
- Stall 2 cycles mid-window: outputs and slot held; window resumes and completes with correct remaining slots.
- it_start while ACTIVE and it_start with len=0 → it_err=1 sticky; reset mid-window → it_active=0, cond_valid=0 next cycle.
